// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the LC-3b memory port arbiter: word/mask types, FSM state,
// grant source, and the tie-break decision used in IDLE.
package mem_port_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;

  // Pick the side that owns the memory port for the next transaction.
  // rr_mode: 1 = round-robin (loser of last grant wins a tie),
  //          0 = D-priority unless the fetch side has been starved too long.
  function automatic arb_src_t pick_winner(input logic     req_i,
                                           input logic     req_d,
                                           input logic     rr_mode,
                                           input arb_src_t last_grant,
                                           input logic     starved);
    arb_src_t win;
    win = SRC_D;
    if (req_i && !req_d) begin
      win = SRC_I;
    end else if (req_i && req_d) begin
      if (rr_mode) begin
        win = (last_grant == SRC_D) ? SRC_I : SRC_D;
      end else begin
        win = starved ? SRC_I : SRC_D;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one LC-3b memory port between instruction fetch (I) and load/store (D).
// The winning command is latched in IDLE and held on the memory port until
// mem_resp; a one-cycle IDLE bubble always follows each completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MASK_W     = 2,
  parameter int ARB_MODE   = 0,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_wmask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_byte_enable,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  // Counter must hold STARVE_MAX; keep at least one bit when STARVE_MAX is 0.
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic RR_MODE = (ARB_MODE == 0);

  arb_state_t        state;
  arb_src_t          last_grant;
  arb_src_t          winner;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [MASK_W-1:0] cmd_mask;
  logic              cmd_rd;
  logic              cmd_wr;
  logic              req_i;
  logic              req_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // Tie-break for the current IDLE cycle.
  always_comb begin
    winner = pick_winner(req_i, req_d, RR_MODE, last_grant, starve_cnt == STARVE_LIM);
  end

  // Arbitration FSM: latch the winner's command in IDLE, hold it until mem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_mask   <= '1;
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
      last_grant <= SRC_D;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            last_grant <= winner;
            if (winner == SRC_I) begin
              state      <= GRANT_I;
              cmd_addr   <= i_addr;
              cmd_wdata  <= '0;
              cmd_mask   <= '1;
              cmd_rd     <= 1'b1;
              cmd_wr     <= 1'b0;
              starve_cnt <= '0;
            end else begin
              state     <= GRANT_D;
              cmd_addr  <= d_addr;
              cmd_wdata <= d_wdata;
              cmd_mask  <= d_wmask;
              // Read+write together is illegal; it resolves to a write.
              cmd_rd    <= d_read & ~d_write;
              cmd_wr    <= d_write;
              if (!RR_MODE && req_i && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
            end
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_resp) begin
            state  <= IDLE;
            cmd_rd <= 1'b0;
            cmd_wr <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cmd_rd <= 1'b0;
          cmd_wr <= 1'b0;
        end
      endcase
    end
  end

  // Memory port is driven purely from the latched command.
  always_comb begin
    mem_read        = cmd_rd;
    mem_write       = cmd_wr;
    mem_address     = cmd_addr;
    mem_wdata       = cmd_wdata;
    mem_byte_enable = cmd_mask;
  end

  // Completion is routed to the granted side in the same cycle as mem_resp.
  always_comb begin
    i_resp  = (state == GRANT_I) && mem_resp;
    d_resp  = (state == GRANT_D) && mem_resp;
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share every input:
// dut_rr uses round-robin, dut_dp uses D-priority with a starvation guard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [15:0] i_addr;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [1:0]  d_wmask;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [1:0]  mem_byte_enable;

  logic [15:0] i_rdata_b, d_rdata_b, mem_address_b, mem_wdata_b;
  logic        i_resp_b, d_resp_b, mem_read_b, mem_write_b;
  logic [1:0]  mem_byte_enable_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ARB_MODE(0), .STARVE_MAX(3)) dut_rr (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_port_arbiter #(.ARB_MODE(1), .STARVE_MAX(3)) dut_dp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_b), .i_resp(i_resp_b),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata_b), .d_resp(d_resp_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
    .mem_wdata(mem_wdata_b), .mem_byte_enable(mem_byte_enable_b),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Simultaneous load and store requests are illegal stimulus.
  always @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write));
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_rdata = '0; mem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b want=0000", {mem_read, mem_write, i_resp, d_resp});
    end
    vectors++;
    if ({mem_address, mem_wdata} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_addr_data got=%h want=00000000", {mem_address, mem_wdata});
    end
    vectors++;
    if (mem_byte_enable !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_mask got=%b want=11", mem_byte_enable);
    end
    vectors++;
    if ({mem_read_b, mem_write_b, mem_byte_enable_b} !== 4'b0011) begin
      miscompares++;
      $display("FAIL reset_dp got=%b want=0011", {mem_read_b, mem_write_b, mem_byte_enable_b});
    end
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    i_read = 1'b1; i_addr = 16'h0040;
    #1;
    vectors++;
    if (mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_idle_read got=%b want=0", mem_read);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      vectors++;
      if ({mem_read, mem_write, mem_address, i_resp} !== {2'b10, 16'h0040, 1'b0}) begin
        miscompares++;
        $display("FAIL fetch_grant c%0d got rd=%b wr=%b addr=%h resp=%b want rd=1 wr=0 addr=0040 resp=0",
                 c, mem_read, mem_write, mem_address, i_resp);
      end
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'h1234; i_read = 1'b0;
    #1;
    vectors++;
    if ({i_resp, d_resp, i_rdata} !== {2'b10, 16'h1234}) begin
      miscompares++;
      $display("FAIL fetch_resp got i_resp=%b d_resp=%b rdata=%h want 1 0 1234", i_resp, d_resp, i_rdata);
    end
    vectors++;
    if (mem_byte_enable !== 2'b11) begin
      miscompares++;
      $display("FAIL fetch_mask got=%b want=11", mem_byte_enable);
    end
    @(negedge clk);
    #1;
    // mem_resp still high in IDLE must not produce a response.
    vectors++;
    if ({mem_read, i_resp, d_resp} !== 3'b000) begin
      miscompares++;
      $display("FAIL fetch_idle_after got=%b want=000", {mem_read, i_resp, d_resp});
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_lone_store_hold();
    @(negedge clk);
    d_write = 1'b1; d_addr = 16'h1002; d_wdata = 16'hBEEF; d_wmask = 2'b01;
    @(negedge clk);
    #1;
    vectors++;
    if ({mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable} !==
        {2'b01, 16'h1002, 16'hBEEF, 2'b01}) begin
      miscompares++;
      $display("FAIL store_grant got rd=%b wr=%b addr=%h wdata=%h be=%b want 0 1 1002 beef 01",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable);
    end
    d_addr = 16'h2000; d_wdata = 16'h5555; d_wmask = 2'b10;
    @(negedge clk);
    #1;
    vectors++;
    if ({mem_address, mem_wdata, mem_byte_enable} !== {16'h1002, 16'hBEEF, 2'b01}) begin
      miscompares++;
      $display("FAIL store_hold got addr=%h wdata=%h be=%b want 1002 beef 01",
               mem_address, mem_wdata, mem_byte_enable);
    end
    mem_resp = 1'b1; d_write = 1'b0;
    #1;
    vectors++;
    if ({d_resp, i_resp, mem_address} !== {2'b10, 16'h1002}) begin
      miscompares++;
      $display("FAIL store_resp got d_resp=%b i_resp=%b addr=%h want 1 0 1002", d_resp, i_resp, mem_address);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    vectors++;
    if ({mem_write, d_resp} !== 2'b00) begin
      miscompares++;
      $display("FAIL store_idle got=%b want=00", {mem_write, d_resp});
    end
  endtask

  // Both sides hold reads; round-robin gives I,D,I,D..., D-priority gives D,D,D,I,...
  task automatic test_tie_order();
    logic        exp_i_rr, exp_i_dp;
    logic [15:0] exp_addr_rr, exp_addr_dp;
    apply_reset();
    i_read = 1'b1; i_addr = 16'h0100; d_read = 1'b1; d_addr = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      exp_i_rr    = (k % 2) == 0;
      exp_i_dp    = (k % 4) == 3;
      exp_addr_rr = exp_i_rr ? 16'h0100 : 16'h0200;
      exp_addr_dp = exp_i_dp ? 16'h0100 : 16'h0200;
      @(negedge clk);
      #1;
      vectors++;
      if ({mem_read, mem_address} !== {1'b1, exp_addr_rr}) begin
        miscompares++;
        $display("FAIL rr_grant k%0d got rd=%b addr=%h want rd=1 addr=%h", k, mem_read, mem_address, exp_addr_rr);
      end
      vectors++;
      if ({mem_read_b, mem_address_b} !== {1'b1, exp_addr_dp}) begin
        miscompares++;
        $display("FAIL dp_grant k%0d got rd=%b addr=%h want rd=1 addr=%h", k, mem_read_b, mem_address_b, exp_addr_dp);
      end
      mem_resp = 1'b1;
      #1;
      vectors++;
      if ({i_resp, d_resp, i_resp_b, d_resp_b} !== {exp_i_rr, !exp_i_rr, exp_i_dp, !exp_i_dp}) begin
        miscompares++;
        $display("FAIL tie_resp k%0d got=%b want=%b", k, {i_resp, d_resp, i_resp_b, d_resp_b},
                 {exp_i_rr, !exp_i_rr, exp_i_dp, !exp_i_dp});
      end
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      vectors++;
      if ({mem_read, mem_read_b} !== 2'b00) begin
        miscompares++;
        $display("FAIL tie_bubble k%0d got=%b want=00", k, {mem_read, mem_read_b});
      end
    end
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    i_read = 1'b1; i_addr = 16'h0300;
    @(negedge clk);
    #1;
    vectors++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0300}) begin
      miscompares++;
      $display("FAIL midrst_grant got rd=%b addr=%h want 1 0300", mem_read, mem_address);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_read = 1'b0; mem_resp = 1'b1;
    #1;
    vectors++;
    if ({mem_read, i_resp, mem_address} !== {2'b00, 16'h0000}) begin
      miscompares++;
      $display("FAIL midrst_idle got rd=%b resp=%b addr=%h want 0 0 0000", mem_read, i_resp, mem_address);
    end
    @(negedge clk);
    mem_resp = 1'b0; i_read = 1'b1; i_addr = 16'h0400;
    @(negedge clk);
    #1;
    vectors++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0400}) begin
      miscompares++;
      $display("FAIL midrst_regrant got rd=%b addr=%h want 1 0400", mem_read, mem_address);
    end
    mem_resp = 1'b1; mem_rdata = 16'hCAFE; i_read = 1'b0;
    #1;
    vectors++;
    if ({i_resp, i_rdata} !== {1'b1, 16'hCAFE}) begin
      miscompares++;
      $display("FAIL midrst_resp got resp=%b rdata=%h want 1 cafe", i_resp, i_rdata);
    end
    @(negedge clk);
    mem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_lone_store_hold();
    test_tie_order();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
